// File: rtl/instr_fetch_stage.sv
// MIPS32 instruction fetch stage: PC, single-outstanding imem fetch, 2-entry decode queue.
// Optional ADDIU predecode bit per queue entry when IF_ADDIU_PREDECODE_EN is defined.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ir_valid,
  input  logic        dec_ready,
  output logic [31:0] ir_data,
  output logic [31:0] ir_pc,
  output logic [5:0]  opcode
`ifdef IF_ADDIU_PREDECODE_EN
  ,
  output logic        is_addiu
`endif
);

  typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] data_q [2];
  logic [31:0] data_d [2];
  logic [31:0] epc_q [2];
  logic [31:0] epc_d [2];
  logic        head_q, head_d;
  logic [1:0]  count_q, count_d;
`ifdef IF_ADDIU_PREDECODE_EN
  logic        addiu_q [2];
  logic        addiu_d [2];
`endif

  logic        rsp_keep;
  logic        pop;
  logic        push_slot;
  logic [31:0] redirect_aligned;

  assign ir_valid         = (count_q != 2'd0);
  assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

  // Queue bookkeeping; a redirect wipes the queue and swallows any same-cycle push or pop.
  always_comb begin
    rsp_keep  = (state_q == ST_WAIT) && imem_rvalid && !redirect_valid;
    pop       = ir_valid && dec_ready && !redirect_valid;
    push_slot = head_q ^ count_q[0];
    count_d   = count_q;
    head_d    = head_q;
    data_d    = data_q;
    epc_d     = epc_q;
`ifdef IF_ADDIU_PREDECODE_EN
    addiu_d   = addiu_q;
`endif
    if (redirect_valid) begin
      count_d = 2'd0;
    end else begin
      if (rsp_keep) begin
        data_d[push_slot] = imem_rdata;
        epc_d[push_slot]  = fetch_pc_q;
`ifdef IF_ADDIU_PREDECODE_EN
        addiu_d[push_slot] = (imem_rdata[31:26] == 6'b001001);
`endif
      end
      if (pop) begin
        head_d = ~head_q;
      end
      if (rsp_keep && !pop) begin
        count_d = count_q + 2'd1;
      end else if (!rsp_keep && pop) begin
        count_d = count_q - 2'd1;
      end
    end
  end

  // Issue only when no fetch will remain outstanding and the queue keeps a free slot.
  always_comb begin
    imem_addr  = redirect_valid ? redirect_aligned : pc_q;
    if (!rst_n) begin
      imem_addr = RESET_PC;
    end
    imem_req   = rst_n && ((state_q == ST_RUN) || imem_rvalid) && (count_d <= 2'd1);
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    state_d    = state_q;
    if (imem_req) begin
      pc_d       = imem_addr + 32'd4;
      fetch_pc_d = imem_addr;
      state_d    = ST_WAIT;
    end else begin
      if (redirect_valid) begin
        pc_d = redirect_aligned;
      end
      if (state_q != ST_RUN) begin
        if (imem_rvalid) begin
          state_d = ST_RUN;
        end else if (redirect_valid) begin
          state_d = ST_DROP;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      head_q     <= 1'b0;
      count_q    <= 2'd0;
      data_q     <= '{default: '0};
      epc_q      <= '{default: '0};
`ifdef IF_ADDIU_PREDECODE_EN
      addiu_q    <= '{default: 1'b0};
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      count_q    <= count_d;
      data_q     <= data_d;
      epc_q      <= epc_d;
`ifdef IF_ADDIU_PREDECODE_EN
      addiu_q    <= addiu_d;
`endif
    end
  end

  always_comb begin
    ir_data = ir_valid ? data_q[head_q] : 32'd0;
    ir_pc   = ir_valid ? epc_q[head_q] : 32'd0;
    opcode  = ir_data[31:26];
`ifdef IF_ADDIU_PREDECODE_EN
    is_addiu = ir_valid && addiu_q[head_q];
`endif
  end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: memory model, stream-level scoreboard, directed and random phases.
module tb_instr_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ir_valid;
  logic        dec_ready;
  logic [31:0] ir_data;
  logic [31:0] ir_pc;
  logic [5:0]  opcode;
`ifdef IF_ADDIU_PREDECODE_EN
  logic        is_addiu;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int lat_cfg  = 1;
  bit lat_rand = 1'b0;
  bit spur_en  = 1'b0;

  bit          mem_out  = 1'b0;
  bit          real_rsp = 1'b0;
  int          resp_cyc = 0;
  logic [31:0] mem_addr = 32'd0;

  logic [31:0] exp_fetch = RST_PC;
  logic [63:0] exp_q[$];
  bit          prev_redir = 1'b0;
  int          idle_run   = 0;
  int          max_idle   = 0;

  always #5 clk = ~clk;

  instr_fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ir_valid       (ir_valid),
    .dec_ready      (dec_ready),
    .ir_data        (ir_data),
    .ir_pc          (ir_pc),
    .opcode         (opcode)
`ifdef IF_ADDIU_PREDECODE_EN
    ,
    .is_addiu       (is_addiu)
`endif
  );

  // Instruction memory contents; two fixed words exercise the ADDIU predecode.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_2000) return 32'h2408_0005;
    if (a == 32'h0000_2004) return 32'h0000_0000;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: inputs change just after the rising edge, outputs are sampled at the falling edge.
  task automatic applyStimulus(input logic rst, input logic rdy, input logic redir,
                               input logic [31:0] rpc);
    @(posedge clk);
    cyc++;
    #1;
    rst_n          = rst;
    dec_ready      = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    real_rsp       = mem_out && (cyc == resp_cyc);
    if (real_rsp) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mem_addr);
    end else if (spur_en && !mem_out && ($urandom_range(0, 3) == 0)) begin
      imem_rvalid = 1'b1;
      imem_rdata  = $urandom;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    @(negedge clk);
  endtask

  // Monitor: the expected decode stream is consecutive words from the last redirect target.
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst_n) begin
      mem_out    = 1'b0;
      exp_q.delete();
      exp_fetch  = RST_PC;
      prev_redir = 1'b0;
      idle_run   = 0;
    end else begin
      if (!ir_valid) begin
        checkOutput("idle_ir_data", ir_data, 32'd0);
        checkOutput("idle_ir_pc", ir_pc, 32'd0);
        checkOutput("idle_opcode", {26'd0, opcode}, 32'd0);
`ifdef IF_ADDIU_PREDECODE_EN
        checkOutput("idle_is_addiu", {31'd0, is_addiu}, 32'd0);
`endif
        idle_run++;
        if (idle_run > max_idle) max_idle = idle_run;
      end else begin
        idle_run = 0;
      end
      if (prev_redir) checkOutput("ir_valid_after_redirect", {31'd0, ir_valid}, 32'd0);
      if (redirect_valid) begin
        exp_q.delete();
        exp_fetch = redirect_pc & 32'hFFFF_FFFC;
        idle_run  = 0;
      end else if (ir_valid && dec_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL pop_expected: got pc %h expected no instruction (cycle %0d)", ir_pc, cyc);
        end else begin
          e = exp_q.pop_front();
          checkOutput("ir_pc", ir_pc, e[63:32]);
          checkOutput("ir_data", ir_data, e[31:0]);
          checkOutput("opcode", {26'd0, opcode}, {26'd0, e[31:26]});
`ifdef IF_ADDIU_PREDECODE_EN
          checkOutput("is_addiu", {31'd0, is_addiu}, {31'd0, (e[31:26] == 6'b001001)});
`endif
        end
      end
      if (real_rsp) mem_out = 1'b0;
      if (imem_req) begin
        checks++;
        if (mem_out) begin
          failures++;
          $display("[TB] FAIL single_outstanding: got 2 fetches outstanding expected 1 (cycle %0d)", cyc);
        end
        checkOutput("imem_addr", imem_addr, exp_fetch);
        exp_q.push_back({exp_fetch, mem_word(exp_fetch)});
        exp_fetch = exp_fetch + 32'd4;
        mem_out   = 1'b1;
        mem_addr  = imem_addr;
        resp_cyc  = cyc + (lat_rand ? int'($urandom_range(1, 3)) : lat_cfg);
      end
      prev_redir = redirect_valid;
    end
  end

  initial begin
    #100000;
    failures++;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          found;
    int          reqs;
    logic [31:0] rpc;
    rst_n = 1'b0; dec_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    imem_rvalid = 1'b0; imem_rdata = 32'd0;

    // Reset values
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("rst_imem_req", {31'd0, imem_req}, 32'd0);
    checkOutput("rst_imem_addr", imem_addr, RST_PC);
    checkOutput("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
    checkOutput("rst_ir_data", ir_data, 32'd0);
    checkOutput("rst_ir_pc", ir_pc, 32'd0);
    checkOutput("rst_opcode", {26'd0, opcode}, 32'd0);
`ifdef IF_ADDIU_PREDECODE_EN
    checkOutput("rst_is_addiu", {31'd0, is_addiu}, 32'd0);
`endif

    // Startup with L=1 and decode always ready
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
      checkOutput("startup_req", {31'd0, imem_req}, 32'd1);
      checkOutput("startup_addr", imem_addr, RST_PC + 32'(4 * i));
      checkOutput("startup_valid", {31'd0, ir_valid}, (i >= 2) ? 32'd1 : 32'd0);
      if (i >= 2) checkOutput("startup_ir_pc", ir_pc, RST_PC + 32'(4 * (i - 2)));
    end

    // Queue fills to two entries while decode stalls
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    reqs = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
      reqs += int'(imem_req);
      if (i >= 2) checkOutput("full_no_req", {31'd0, imem_req}, 32'd0);
    end
    checkOutput("full_req_count", reqs, 32'd2);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    checkOutput("resume_pop_pc", ir_pc, RST_PC);
    checkOutput("resume_req", {31'd0, imem_req}, 32'd1);
    checkOutput("resume_addr", imem_addr, RST_PC + 32'd8);
    repeat (6) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);

    // L=3, redirect one cycle after a request drops the late response
    lat_cfg = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
      found = imem_req;
    end
    checkOutput("l3_req_seen", {31'd0, found}, 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_1003);
    checkOutput("drop_no_req_0", {31'd0, imem_req}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    checkOutput("drop_no_req_1", {31'd0, imem_req}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    checkOutput("drop_refetch_req", {31'd0, imem_req}, 32'd1);
    checkOutput("drop_refetch_addr", imem_addr, 32'h0000_1000);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
      found = ir_valid;
    end
    checkOutput("drop_first_seen", {31'd0, found}, 32'd1);
    checkOutput("drop_first_pc", ir_pc, 32'h0000_1000);

    // L=1 steady state; redirect coincides with a response and a pop
    lat_cfg = 1;
    repeat (8) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_1000);
    checkOutput("redir_pop_present", {31'd0, ir_valid}, 32'd1);
    checkOutput("redir_req", {31'd0, imem_req}, 32'd1);
    checkOutput("redir_addr", imem_addr, 32'h0000_1000);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    checkOutput("redir_next_valid", {31'd0, ir_valid}, 32'd0);
    checkOutput("redir_next_addr", imem_addr, 32'h0000_1004);

    // PC wrap at the top of the address space
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    checkOutput("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    checkOutput("wrap_req", {31'd0, imem_req}, 32'd1);
    checkOutput("wrap_addr_zero", imem_addr, 32'h0000_0000);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    checkOutput("wrap_ir_pc", ir_pc, 32'hFFFF_FFFC);

    // ADDIU word followed by an all-zero word
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_2000);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    checkOutput("addiu_pc", ir_pc, 32'h0000_2000);
    checkOutput("addiu_opcode", {26'd0, opcode}, 32'h0000_0009);
`ifdef IF_ADDIU_PREDECODE_EN
    checkOutput("addiu_flag", {31'd0, is_addiu}, 32'd1);
`endif
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    checkOutput("nop_pc", ir_pc, 32'h0000_2004);
    checkOutput("nop_opcode", {26'd0, opcode}, 32'd0);
`ifdef IF_ADDIU_PREDECODE_EN
    checkOutput("nop_flag", {31'd0, is_addiu}, 32'd0);
`endif

    // Reset in the middle of a fetch; stray strobes afterwards must be ignored
    lat_cfg = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
      found = imem_req;
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    spur_en = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    checkOutput("rerst_req", {31'd0, imem_req}, 32'd1);
    checkOutput("rerst_addr", imem_addr, RST_PC);

    // Random traffic: latency 1..3, stalls, redirects, stray strobes
    lat_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       rpc = 32'h0000_2000;
        1:       rpc = 32'hFFFF_FFF8 | 32'($urandom_range(0, 3));
        default: rpc = $urandom;
      endcase
      applyStimulus(1'b1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0), rpc);
    end
    lat_rand = 1'b0;
    lat_cfg  = 1;
    spur_en  = 1'b0;
    repeat (20) applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    checkOutput("idle_bound", {31'd0, (max_idle <= 10)}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
